hazard_scoreboard: RTL and testbench

//  Hazard unit for the non-forwarding pipeline. It sits at the ID end of the ID/EX

---
 rtl/hazard_scoreboard.sv | 93 +++++++++
 tb/tb_hazard_scoreboard.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard unit for a non-forwarding pipeline. It keeps a pending-write countdown for each register,
// stalls ID on a read-after-write hazard, and rolls back the entry of an instruction that a flush squashes.
module hazard_scoreboard #(
    parameter int unsigned NREG    = 32,
    parameter int unsigned WB_DIST = 2,
    parameter int unsigned CW      = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [4:0]      id_rs,
    input  logic [4:0]      id_rt,
    input  logic            id_use_rs,
    input  logic            id_use_rt,
    input  logic            id_wr_en,
    input  logic [4:0]      id_wr_reg,
    input  logic            flush,
    output logic            stall,
    output logic            idex_bubble,
    output logic [NREG-1:0] busy_mask,
    output logic [31:0]     stall_cnt
);

    localparam logic [CW-1:0] WbDist = CW'(WB_DIST);

    function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] x);
        return (x == '0) ? '0 : x - CW'(1);
    endfunction

    logic [CW-1:0] cnt_q [NREG];
    logic [CW-1:0] cnt_d [NREG];
    logic          last_vld_q,  last_vld_d;
    logic [4:0]    last_reg_q,  last_reg_d;
    logic [CW-1:0] last_prev_q, last_prev_d;
    logic [31:0]   stall_cnt_q, stall_cnt_d;
    logic          haz;
    logic          issue;

    always_comb begin
        busy_mask = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            busy_mask[r] = (cnt_q[r] != '0);
        end
    end

    always_comb begin
        haz         = id_valid & ((id_use_rs & busy_mask[id_rs]) | (id_use_rt & busy_mask[id_rt]));
        stall       = haz & ~flush;
        idex_bubble = haz | flush;
        issue       = id_valid & ~haz & ~flush & id_wr_en & (id_wr_reg != 5'd0);
    end

    always_comb begin
        cnt_d[0] = '0;
        for (int unsigned r = 1; r < NREG; r++) begin
            // A squashed writer hands the register back to whatever the older writer holds now.
            if (flush && last_vld_q && (last_reg_q == 5'(r))) begin
                cnt_d[r] = sat_dec(last_prev_q);
            end else if (issue && (id_wr_reg == 5'(r))) begin
                cnt_d[r] = WbDist;
            end else begin
                cnt_d[r] = sat_dec(cnt_q[r]);
            end
        end
        last_vld_d  = issue;
        last_reg_d  = issue ? id_wr_reg : last_reg_q;
        last_prev_d = issue ? sat_dec(cnt_q[id_wr_reg]) : last_prev_q;
        stall_cnt_d = (stall && (stall_cnt_q != 32'hFFFF_FFFF)) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
            last_vld_q  <= 1'b0;
            last_reg_q  <= 5'd0;
            last_prev_q <= '0;
            stall_cnt_q <= 32'd0;
        end else begin
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            last_vld_q  <= last_vld_d;
            last_reg_q  <= last_reg_d;
            last_prev_q <= last_prev_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard. The reference model tracks in-flight writers by the edge
// at which each one issued, and a negedge monitor compares every cycle against the queued expectations.
module tb_hazard_scoreboard;

    localparam int WbDist = 2;

    logic        clk = 1'b0;
    logic        rst_n, id_valid, id_use_rs, id_use_rt, id_wr_en, flush;
    logic [4:0]  id_rs, id_rt, id_wr_reg;
    logic        stall, idex_bubble;
    logic [31:0] busy_mask, stall_cnt;

    hazard_scoreboard dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_use_rs   (id_use_rs),
        .id_use_rt   (id_use_rt),
        .id_wr_en    (id_wr_en),
        .id_wr_reg   (id_wr_reg),
        .flush       (flush),
        .stall       (stall),
        .idex_bubble (idex_bubble),
        .busy_mask   (busy_mask),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        bubble;
        logic [31:0] busy;
        logic [31:0] scnt;
    } exp_t;

    typedef struct {
        int rg;
        int e;
    } wr_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    wr_t         wq[$];
    int          ecnt  = 0;
    bit          known = 0;
    logic [31:0] m_scnt = '0;
    int          errs = 0;
    int          checks = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // A writer issued at edge e is pending after edges e .. e+WbDist-1.
    function automatic bit m_busy(int r);
        foreach (wq[i]) begin
            if (wq[i].rg == r && (ecnt - wq[i].e) < WbDist) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [4:0] rreg();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
    endfunction

    task automatic step(input bit v, input logic [4:0] rs, input logic [4:0] rt, input bit urs,
                        input bit urt, input bit we, input logic [4:0] wr, input bit fl,
                        input bit rn);
        exp_t e;
        bit   hz, iss;
        int   k;
        @(posedge clk);
        #1;
        id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_wr_en = we; id_wr_reg = wr; flush = fl; rst_n = rn;
        hz       = v && ((urs && m_busy(int'(rs))) || (urt && m_busy(int'(rt))));
        e.stall  = hz && !fl;
        e.bubble = hz || fl;
        e.scnt   = m_scnt;
        for (int r = 0; r < 32; r++) e.busy[r] = m_busy(r);
        if (known) exp_q.push_back(e);
        iss = v && !hz && !fl && we && (wr != 5'd0);
        k = ecnt + 1;
        if (!rn) begin
            wq.delete();
            m_scnt = '0;
            known  = 1'b1;
        end else begin
            if (fl) begin
                for (int i = wq.size() - 1; i >= 0; i--) if (wq[i].e == k - 1) wq.delete(i);
            end
            if (e.stall && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 32'd1;
            if (iss) wq.push_back('{rg: int'(wr), e: k});
        end
        ecnt = k;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("stall", 32'(stall), 32'(mon_e.stall));
            chk("idex_bubble", 32'(idex_bubble), 32'(mon_e.bubble));
            chk("busy_mask", busy_mask, mon_e.busy);
            chk("stall_cnt", stall_cnt, mon_e.scnt);
        end
    end

    initial begin
        rst_n = 0; id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        id_wr_en = 0; id_wr_reg = 0; flush = 0;

        // Reset held for two edges with random inputs.
        for (int i = 0; i < 2; i++)
            step(1, rreg(), rreg(), 1, 1, 1, rreg(), 1'($urandom_range(0, 1)), 0);
        @(negedge clk);
        chk("rst_busy", busy_mask, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_scnt", stall_cnt, 32'd0);

        // Producer $3 followed by a dependent reader: two bubbles.
        step(1, 0, 0, 0, 0, 1, 3, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 3, 0, 1, 0, 1, 8, 0, 1);
            @(negedge clk);
            chk("raw_stall", 32'(stall), (i < 2) ? 32'd1 : 32'd0);
            chk("raw_bubble", 32'(idex_bubble), (i < 2) ? 32'd1 : 32'd0);
        end
        chk("raw_scnt", stall_cnt, 32'd2);

        // $0 is never pending.
        idle(3);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 1, 1, 1, 0, 0, 1);
            @(negedge clk);
            chk("r0_stall", 32'(stall), 32'd0);
            chk("r0_busy", busy_mask, 32'd0);
        end

        // Back-to-back writers of $5 reload the countdown.
        step(1, 0, 0, 0, 0, 1, 5, 0, 1);
        step(1, 0, 0, 0, 0, 1, 5, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 5, 0, 1, 0, 0, 0, 0, 1);
            @(negedge clk);
            chk("rewr_stall", 32'(stall), (i < 2) ? 32'd1 : 32'd0);
        end

        // Flushed lw $7 leaves no pending entry.
        idle(3);
        step(1, 0, 0, 0, 0, 1, 7, 0, 1);
        step(1, 7, 0, 1, 0, 0, 0, 1, 1);
        @(negedge clk);
        chk("fl_stall", 32'(stall), 32'd0);
        chk("fl_bubble", 32'(idex_bubble), 32'd1);
        step(1, 7, 0, 1, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("fl_busy7", 32'(busy_mask[7]), 32'd0);
        chk("fl_nostall", 32'(stall), 32'd0);

        // Two writers of $4, the younger one flushed: restore from the older.
        idle(3);
        step(1, 0, 0, 0, 0, 1, 4, 0, 1);
        step(1, 0, 0, 0, 0, 1, 4, 0, 1);
        step(1, 4, 0, 1, 0, 0, 0, 1, 1);
        @(negedge clk);
        chk("rb_stall", 32'(stall), 32'd0);
        chk("rb_bubble", 32'(idex_bubble), 32'd1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("rb_busy4", 32'(busy_mask[4]), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++)
            step($urandom_range(0, 7) != 0, rreg(), rreg(), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, rreg(),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 63) != 0);

        @(negedge clk);
        @(negedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
